// File: rtl/odd_even_sort_hs_if.sv
// odd_even_sort_hs_if: vector-in / sorted-vector-out handshake bundle for odd_even_sort_hs
interface odd_even_sort_hs_if #(
    parameter int N = 16,
    parameter int W = 8
);
    localparam int PW = $clog2(N + 1);
    logic [W*N-1:0] din;
    logic           descend;
    logic           in_valid;
    logic           in_ready;
    logic [W*N-1:0] dout;
    logic           out_valid;
    logic           out_ready;
    logic [PW-1:0]  phases;
    modport master (output din, descend, in_valid, out_ready, input in_ready, dout, out_valid, phases);
    modport slave  (input din, descend, in_valid, out_ready, output in_ready, dout, out_valid, phases);
endinterface

// File: rtl/odd_even_sort_hs.sv
// odd_even_sort_hs: iterative odd-even transposition sorter, one compare-exchange phase per clock,
// with run-time direction, optional signed compare, early exit and a phase-count report
module odd_even_sort_hs #(
    parameter int N          = 16,
    parameter int W          = 8,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input logic               clk,
    input logic               rst,
    odd_even_sort_hs_if.slave s
);
    localparam int PW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
    state_t               state, state_nxt;
    logic [N-1:0][W-1:0]  arr, arr_nxt;
    logic [PW-1:0]        cnt;
    logic                 desc, prev_sw, any_sw, last;

    function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
        return (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    // cnt doubles as the current phase index while sorting, so its LSB picks the pair parity
    always_comb begin
        arr_nxt = arr;
        any_sw  = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2) == int'(cnt[0]) && (desc ? gt(arr[i+1], arr[i]) : gt(arr[i], arr[i+1]))) begin
                arr_nxt[i]   = arr[i+1];
                arr_nxt[i+1] = arr[i];
                any_sw       = 1'b1;
            end
        end
    end

    assign last = (cnt == PW'(N - 1)) ||
                  (EARLY_EXIT != 0 && cnt != '0 && !any_sw && !prev_sw);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = s.in_valid ? SORT : IDLE;
            SORT:    state_nxt = last ? DONE : SORT;
            DONE:    state_nxt = s.out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s.in_ready  = (state == IDLE);
        s.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr     <= '0;
            cnt     <= '0;
            desc    <= 1'b0;
            prev_sw <= 1'b0;
        end else if (state == IDLE && s.in_valid) begin
            arr     <= s.din;
            cnt     <= '0;
            desc    <= s.descend;
            prev_sw <= 1'b0;
        end else if (state == SORT) begin
            arr     <= arr_nxt;
            cnt     <= cnt + PW'(1);
            prev_sw <= any_sw;
        end
    end

    assign s.dout   = arr;
    assign s.phases = cnt;
endmodule

// File: tb/tb_odd_even_sort_hs.sv
// tb_odd_even_sort_hs: directed checks of odd_even_sort_hs across early-exit, signedness and handshake cases
module tb_odd_even_sort_hs;
    localparam logic [127:0] V1   = 128'h3c4d5a1a6f31147b3e016e7b1111337a;
    localparam logic [127:0] ASC  = 128'h7b7b7a6f6e5a4d3e3c33311a14111101;
    localparam logic [127:0] DSC  = 128'h011111141a31333c3e4d5a6e6f7a7b7b;
    localparam logic [127:0] SRTD = 128'h0f0e0d0c0b0a09080706050403020100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int la, lb;
    logic [127:0] da, db;
    logic [4:0]   pa, pb;

    odd_even_sort_hs_if #(.N(16), .W(8)) ie ();
    odd_even_sort_hs_if #(.N(16), .W(8)) in0 ();
    odd_even_sort_hs_if #(.N(4), .W(8))  is ();
    odd_even_sort_hs_if #(.N(4), .W(8))  iu ();

    odd_even_sort_hs #(.N(16), .W(8), .SIGNED(0), .EARLY_EXIT(1)) u_e  (.clk(clk), .rst(rst), .s(ie));
    odd_even_sort_hs #(.N(16), .W(8), .SIGNED(0), .EARLY_EXIT(0)) u_n  (.clk(clk), .rst(rst), .s(in0));
    odd_even_sort_hs #(.N(4),  .W(8), .SIGNED(1), .EARLY_EXIT(1)) u_s  (.clk(clk), .rst(rst), .s(is));
    odd_even_sort_hs #(.N(4),  .W(8), .SIGNED(0), .EARLY_EXIT(1)) u_u  (.clk(clk), .rst(rst), .s(iu));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // feeds both N=16 instances and records the first result each one flags valid
    task automatic run16(input logic [127:0] v, input logic d);
        @(negedge clk);
        check("in_ready_idle", {ie.in_ready, in0.in_ready}, 2'b11);
        ie.din = v; in0.din = v; ie.descend = d; in0.descend = d;
        ie.in_valid = 1'b1; in0.in_valid = 1'b1;
        @(posedge clk); #1;
        ie.in_valid = 1'b0; in0.in_valid = 1'b0;
        la = 0; lb = 0; da = '0; db = '0; pa = '0; pb = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ie.out_valid && la == 0) begin la = k; da = ie.dout; pa = ie.phases; end
            if (in0.out_valid && lb == 0) begin lb = k; db = in0.dout; pb = in0.phases; end
        end
    endtask

    initial begin
        ie.din = '0;  ie.descend = 0;  ie.in_valid = 0;  ie.out_ready = 1;
        in0.din = '0; in0.descend = 0; in0.in_valid = 0; in0.out_ready = 1;
        is.din = '0;  is.descend = 0;  is.in_valid = 0;  is.out_ready = 1;
        iu.din = '0;  iu.descend = 0;  iu.in_valid = 0;  iu.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", ie.dout, '0);
        check("rst_phases", ie.phases, '0);
        check("rst_out_valid", {ie.out_valid, in0.out_valid}, 2'b00);
        @(negedge clk) rst = 1'b1;
        #1 check("rst_in_ready", ie.in_ready, 1'b1);

        run16(V1, 1'b0);
        check("asc_ee_dout", da, ASC);
        check("asc_ee_lat_ok", (la >= 1 && la <= 16), 1'b1);
        check("asc_ee_phases", pa, la);
        check("asc_ne_dout", db, ASC);
        check("asc_ne_lat", lb, 16);
        check("asc_ne_phases", pb, 16);

        run16(V1, 1'b1);
        check("dsc_ee_dout", da, DSC);
        check("dsc_ne_dout", db, DSC);

        run16(SRTD, 1'b0);
        check("srt_ee_lat", la, 2);
        check("srt_ee_phases", pa, 2);
        check("srt_ee_dout", da, SRTD);
        check("srt_ne_lat", lb, 16);
        check("srt_ne_phases", pb, 16);
        check("srt_ne_dout", db, SRTD);

        @(negedge clk);
        is.din = 32'hff00807f; iu.din = 32'hff00807f;
        is.in_valid = 1'b1; iu.in_valid = 1'b1;
        @(posedge clk); #1;
        is.in_valid = 1'b0; iu.in_valid = 1'b0;
        la = 0; lb = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (is.out_valid && la == 0) begin la = k; da = 128'(is.dout); end
            if (iu.out_valid && lb == 0) begin lb = k; db = 128'(iu.dout); end
        end
        check("n4_signed_dout", da, 128'h7f00ff80);
        check("n4_unsigned_dout", db, 128'hff807f00);
        check("n4_done", {la != 0, lb != 0}, 2'b11);

        ie.out_ready = 1'b0;
        @(negedge clk);
        ie.din = SRTD; ie.descend = 1'b0; ie.in_valid = 1'b1;
        @(posedge clk); #1 ie.in_valid = 1'b0;
        la = 0;
        for (int k = 1; k <= 8 && la == 0; k++) begin
            @(posedge clk); #1;
            if (ie.out_valid) la = k;
        end
        check("bp_lat", la, 2);
        da = ie.dout; pa = ie.phases;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin ie.din = V1; ie.in_valid = 1'b1; end
            @(posedge clk); #1 ie.in_valid = 1'b0;
            check("bp_hold_valid", ie.out_valid, 1'b1);
            check("bp_hold_in_ready", ie.in_ready, 1'b0);
            check("bp_hold_dout", ie.dout, SRTD);
            check("bp_hold_phases", ie.phases, 2);
        end
        ie.out_ready = 1'b1;
        @(posedge clk); #1 ie.out_ready = 1'b0;
        check("bp_release_valid", ie.out_valid, 1'b0);
        check("bp_release_in_ready", ie.in_ready, 1'b1);
        check("bp_ignored_din", ie.dout, da);
        ie.out_ready = 1'b1;

        @(negedge clk);
        ie.din = V1; in0.din = V1; ie.descend = 0; in0.descend = 0;
        ie.in_valid = 1'b1; in0.in_valid = 1'b1;
        @(posedge clk); #1;
        ie.in_valid = 1'b0; in0.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_busy", in0.out_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_out_valid", in0.out_valid, 1'b0);
        check("arst_dout", in0.dout, '0);
        check("arst_phases", in0.phases, '0);
        check("arst_dout_ee", ie.dout, '0);
        @(negedge clk) rst = 1'b1;
        #1 check("post_rst_in_ready", {ie.in_ready, in0.in_ready}, 2'b11);
        run16(V1, 1'b0);
        check("post_rst_ee_dout", da, ASC);
        check("post_rst_ne_dout", db, ASC);
        check("post_rst_ne_phases", pb, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
